// File: rtl/wb_pkg.sv
// Shared definitions for the writeback queue: opcodes, load funct3 codes
// and the queue entry layout. Entry fields are sized for the widest
// supported datapath; narrower instances zero-fill the upper bits.
package wb_pkg;

  localparam int XLEN_MAX = 64;
  localparam int OFFW_MAX = 3;

  // Opcodes that change how an entry retires or what it writes back
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Load size/sign selects
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [OFFW_MAX-1:0] addr_lo;
    logic [XLEN_MAX-1:0] alu_res;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner: shifts the raw bus word down by the byte offset,
// then sign- or zero-extends according to funct3. Misaligned accesses
// return 0 with misalign set; illegal funct3 codes return 0 silently.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] raw,
  input  logic [OFFW-1:0] addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw >> {addr_lo, 3'b000};

  // Size, sign and alignment decode for the selected load type.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LH: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            data = XLEN'($signed(shifted[15:0]));
      end
      F3_LHU: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            data = XLEN'(shifted[15:0]);
      end
      F3_LW: begin
        if (addr_lo[1:0] != 2'b00) misalign = 1'b1;
        else                       data = XLEN'($signed(shifted[31:0]));
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          if (addr_lo[1:0] != 2'b00) misalign = 1'b1;
          else                       data = XLEN'(shifted[31:0]);
        end
      end
      F3_LD: begin
        if (XLEN == 64) begin
          if (addr_lo != '0) misalign = 1'b1;
          else               data = shifted;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue between the memory stage and the register file.
// Holds up to DEPTH retiring instructions; a load at the head waits for its
// memory response, everything else retires as soon as it reaches the head.
// One registered register-file write per cycle.
// Optional feature: define WB_BYPASS_EN to drive byp_* with the retiring
// result one cycle ahead of wb_*; otherwise byp_* are tied to 0.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int OFFW = $clog2(XLEN / 8),
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [2:0]      in_funct3,
  input  logic [OFFW-1:0] in_addr_lo,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_enable,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign,
  output logic [CNTW-1:0] occupancy,
  output logic            byp_valid,
  output logic [4:0]      byp_rd,
  output logic [XLEN-1:0] byp_data
);

  localparam int PTRW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  wb_entry_t       in_entry;
  wb_entry_t       head;
  logic [PTRW-1:0] head_ptr;
  logic [PTRW-1:0] tail_ptr;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_next;
  logic            ready_q;
  logic            empty;
  logic            head_is_load;
  logic            push;
  logic            pop;
  logic            no_write;
  logic            wb_we;
  logic [XLEN-1:0] load_data;
  logic            load_misalign;
  logic [XLEN-1:0] result;
  logic            unused_head;

  assign empty         = (count == '0);
  assign head          = mem[head_ptr];
  assign head_is_load  = (head.opcode == OP_LOAD);
  assign push          = in_valid && ready_q;
  assign pop           = !empty && (!head_is_load || mem_rsp_valid);
  assign mem_rsp_ready = !empty && head_is_load;
  assign in_ready      = ready_q;
  assign occupancy     = count;
  // Upper bits of the wide entry are unused on narrow datapaths.
  assign unused_head   = ^head;

  // Pack the incoming instruction into a queue entry.
  always_comb begin
    in_entry         = '0;
    in_entry.pc      = XLEN_MAX'(in_pc);
    in_entry.opcode  = in_opcode;
    in_entry.rd      = in_rd;
    in_entry.funct3  = in_funct3;
    in_entry.addr_lo = OFFW_MAX'(in_addr_lo);
    in_entry.alu_res = XLEN_MAX'(in_alu_res);
  end

  // Entry storage, written at the tail on every accepted push.
  // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[tail_ptr] <= in_entry;
  end

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // Queue pointers, occupancy and the registered accept flag.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count   <= count_next;
      ready_q <= (count_next != CNTW'(DEPTH));
    end
  end

  wb_load_align #(.XLEN(XLEN)) u_align (
    .raw      (mem_rsp_data),
    .addr_lo  (head.addr_lo[OFFW-1:0]),
    .funct3   (head.funct3),
    .data     (load_data),
    .misalign (load_misalign)
  );

  // Result select for the head entry by instruction class.
  always_comb begin
    result = head.alu_res[XLEN-1:0];
    if (head.opcode == OP_JAL || head.opcode == OP_JALR) result = head.pc[XLEN-1:0] + XLEN'(4);
    else if (head_is_load)                              result = load_data;
  end

  assign no_write = (head.opcode == OP_STORE) || (head.opcode == OP_BRANCH);
  assign wb_we    = pop && (head.rd != 5'd0) && !no_write;

  // Register-file write port: strobes every cycle, address/data only on a write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_enable   <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_misalign <= 1'b0;
    end else begin
      wb_enable   <= wb_we;
      wb_misalign <= pop && head_is_load && load_misalign;
      if (wb_we) begin
        wb_rd   <= head.rd;
        wb_data <= result;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = wb_we;
  assign byp_rd    = head.rd;
  assign byp_data  = result;
`else
  assign byp_valid = 1'b0;
  assign byp_rd    = '0;
  assign byp_data  = '0;
`endif

endmodule
